// File: rtl/p2_stopwatch_counter.sv
// MM:SS stopwatch in four BCD digits, advanced by a prescaled, synchronised
// and edge-detected copy of the divider output; run/pause and clear from buttons.
module p2_stopwatch_counter #(
    parameter int unsigned TICKS_PER_SEC = 1
) (
    input  logic       clockin,
    input  logic       resetn,
    input  logic       tick_in,
    input  logic       run_tgl,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       wrap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [7:0] PRESC_MAX = 8'(TICKS_PER_SEC - 1);

    state_t     state;
    state_t     state_nx;

    logic       sync1;
    logic       sync2;
    logic       prev;
    logic       tick_pulse;

    logic [7:0] presc;
    logic [7:0] presc_nx;
    logic       sec_evt;

    logic [3:0] so_nx;
    logic [3:0] st_nx;
    logic [3:0] mo_nx;
    logic [3:0] mt_nx;
    logic       rollover;

    // tick_in is asynchronous: two flops before anything looks at it
    always_ff @(posedge clockin or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= tick_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign tick_pulse = sync2 & ~prev;

    always_ff @(posedge clockin or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = IDLE;
        end else if (run_tgl) begin
            case (state)
                IDLE:    state_nx = RUN;
                RUN:     state_nx = PAUSE;
                PAUSE:   state_nx = RUN;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        running = (state == RUN);
    end

    // Counting decisions use the current state, so a toggle on the same edge
    // still lets a RUN increment land and still blocks a PAUSE tick.
    assign sec_evt = (state == RUN) && tick_pulse && (presc == PRESC_MAX);

    always_comb begin
        presc_nx = presc;
        if ((state == RUN) && tick_pulse) begin
            presc_nx = (presc == PRESC_MAX) ? '0 : presc + 8'd1;
        end
    end

    always_comb begin
        so_nx    = sec_ones;
        st_nx    = sec_tens;
        mo_nx    = min_ones;
        mt_nx    = min_tens;
        rollover = 1'b0;
        if (sec_evt) begin
            if (sec_ones != 4'd9) begin
                so_nx = sec_ones + 4'd1;
            end else begin
                so_nx = '0;
                if (sec_tens != 4'd5) begin
                    st_nx = sec_tens + 4'd1;
                end else begin
                    st_nx = '0;
                    if (min_ones != 4'd9) begin
                        mo_nx = min_ones + 4'd1;
                    end else begin
                        mo_nx = '0;
                        if (min_tens != 4'd5) begin
                            mt_nx = min_tens + 4'd1;
                        end else begin
                            mt_nx    = '0;
                            rollover = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // clear outranks any increment or rollover on the same edge
    always_ff @(posedge clockin or negedge resetn) begin
        if (!resetn) begin
            presc    <= '0;
            sec_ones <= '0;
            sec_tens <= '0;
            min_ones <= '0;
            min_tens <= '0;
            wrap     <= 1'b0;
        end else if (clear) begin
            presc    <= '0;
            sec_ones <= '0;
            sec_tens <= '0;
            min_ones <= '0;
            min_tens <= '0;
            wrap     <= 1'b0;
        end else begin
            presc    <= presc_nx;
            sec_ones <= so_nx;
            sec_tens <= st_nx;
            min_ones <= mo_nx;
            min_tens <= mt_nx;
            wrap     <= rollover;
        end
    end

endmodule

// File: tb/tb_p2_stopwatch_counter.sv
// Scoreboard bench for p2_stopwatch_counter: a seconds/ticks reference model
// queues every expected output change; a monitor pops on each observed change.
module tb_p2_stopwatch_counter;

    localparam int TPS = 2;

    logic       clockin = 1'b0;
    logic       resetn  = 1'b0;
    logic       tick_in = 1'b0;
    logic       run_tgl = 1'b0;
    logic       clear   = 1'b0;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       running;
    logic       wrap;

    p2_stopwatch_counter #(.TICKS_PER_SEC(TPS)) dut (
        .clockin  (clockin),
        .resetn   (resetn),
        .tick_in  (tick_in),
        .run_tgl  (run_tgl),
        .clear    (clear),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .min_ones (min_ones),
        .min_tens (min_tens),
        .running  (running),
        .wrap     (wrap)
    );

    always #5 clockin = ~clockin;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [17:0] expq[$];
    logic [17:0] obs;
    assign obs = {min_tens, min_ones, sec_tens, sec_ones, running, wrap};

    // Reference model: elapsed seconds, ticks since last second, mode 0/1/2 = idle/run/pause
    int          m_secs = 0;
    int          m_acc  = 0;
    int          m_mode = 0;
    logic [17:0] m_last = '0;

    function automatic logic [17:0] model_vec(bit w);
        int mm = m_secs / 60;
        int ss = m_secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), (m_mode == 1), w};
    endfunction

    function automatic void publish(bit w);
        logic [17:0] v = model_vec(w);
        if (v != m_last) begin
            expq.push_back(v);
            m_last = v;
        end
    endfunction

    function automatic void model_event(bit tick, bit tgl, bit clr);
        bit w = 1'b0;
        if (clr) begin
            m_secs = 0;
            m_acc  = 0;
            m_mode = 0;
        end else begin
            if (tick && m_mode == 1) begin
                m_acc++;
                if (m_acc == TPS) begin
                    m_acc = 0;
                    m_secs++;
                    if (m_secs == 3600) begin
                        m_secs = 0;
                        w = 1'b1;
                    end
                end
            end
            if (tgl) m_mode = (m_mode == 1) ? 2 : 1;
        end
        publish(w);
        if (w) publish(1'b0);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every change of the observable outputs must match the queue head
    initial begin
        logic [17:0] last;
        logic [17:0] e;
        int          wcnt;
        last = '0;
        wcnt = 0;
        forever begin
            @(negedge clockin);
            if (!resetn) begin
                last = obs;
                wcnt = 0;
            end else begin
                if (obs != last) begin
                    n_cmp++;
                    if (expq.size() == 0) begin
                        n_bad++;
                        $display("FAIL sb_unexpected: got %h expected no change", obs);
                    end else begin
                        e = expq.pop_front();
                        if (e !== obs) begin
                            n_bad++;
                            $display("FAIL sb_value: got %h expected %h", obs, e);
                        end
                    end
                    last = obs;
                end
                if (wrap) begin
                    wcnt++;
                end else if (wcnt != 0) begin
                    n_cmp++;
                    if (wcnt != 1) begin
                        n_bad++;
                        $display("FAIL wrap_width: got %0d cycles expected 1", wcnt);
                    end
                    wcnt = 0;
                end
            end
        end
    end

    // One tick_in pulse; side 1/2 lands run_tgl/clear on the edge the tick acts on
    task automatic do_tick(int side);
        @(negedge clockin);
        model_event(1'b1, side == 1, side == 2);
        tick_in = 1'b1;
        @(negedge clockin);
        @(negedge clockin);
        if (side == 1) run_tgl = 1'b1;
        if (side == 2) clear   = 1'b1;
        @(negedge clockin);
        run_tgl = 1'b0;
        clear   = 1'b0;
        tick_in = 1'b0;
        @(negedge clockin);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) do_tick(0);
    endtask

    task automatic press(bit is_clr);
        @(negedge clockin);
        model_event(1'b0, !is_clr, is_clr);
        if (is_clr) clear = 1'b1;
        else        run_tgl = 1'b1;
        @(negedge clockin);
        clear   = 1'b0;
        run_tgl = 1'b0;
    endtask

    task automatic restart();
        press(1'b1);
        press(1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;

        // Reset with tick_in toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clockin);
            tick_in = ~tick_in;
        end
        check("rst_outputs", obs, 0);
        tick_in = 1'b0;
        repeat (3) @(negedge clockin);
        resetn = 1'b1;
        repeat (4) @(negedge clockin);
        check("rst_release", obs, 0);

        // First-increment latency
        press(1'b0);
        do_tick(0);
        @(negedge clockin);
        model_event(1'b1, 1'b0, 1'b0);
        tick_in = 1'b1;
        @(posedge clockin); #1;
        check("lat_edge1", sec_ones, 0);
        @(posedge clockin); #1;
        check("lat_edge2", sec_ones, 0);
        @(posedge clockin); #1;
        check("lat_edge3", sec_ones, 1);
        @(negedge clockin);
        tick_in = 1'b0;
        repeat (2) @(negedge clockin);

        // Count to 01:10
        ticks(69 * TPS);
        check("count_0110", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0110);
        check("count_running", running, 1);

        // Prescale, pause, resume
        restart();
        ticks(5);
        check("presc_0002", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0002);
        press(1'b0);
        ticks(4);
        check("pause_hold", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0002);
        check("pause_running", running, 0);
        press(1'b0);
        ticks(1);
        check("resume_0003", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0003);

        // Rollover
        restart();
        ticks(3599 * TPS);
        check("roll_5959", {min_tens, min_ones, sec_tens, sec_ones}, 16'h5959);
        ticks(TPS);
        check("roll_0000", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
        check("roll_running", running, 1);

        // clear on the incrementing edge
        restart();
        ticks(41 * TPS - 1);
        do_tick(2);
        check("clr_inc_time", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
        check("clr_inc_idle", {running, wrap}, 0);

        // run_tgl on the incrementing edge in RUN
        restart();
        ticks(8 * TPS - 1);
        do_tick(1);
        check("tgl_inc_time", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0008);
        check("tgl_inc_pause", running, 0);

        // run_tgl with a tick in PAUSE: tick dropped
        do_tick(1);
        check("tgl_pause_time", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0008);
        check("tgl_pause_run", running, 1);
        ticks(TPS - 1);
        check("tgl_pause_drop", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0008);
        ticks(1);
        check("tgl_pause_next", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0009);

        // Randomised mix
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      do_tick(0);
            else if (r < 80) press(1'b0);
            else if (r < 84) press(1'b1);
            else if (r < 92) do_tick(1);
            else             do_tick(2);
        end

        // Async reset mid-count at 12:34
        restart();
        ticks(754 * TPS);
        check("pre_rst_1234", {min_tens, min_ones, sec_tens, sec_ones}, 16'h1234);
        check("pre_rst_drain", expq.size(), 0);
        @(posedge clockin);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_now", obs, 0);
        m_secs = 0;
        m_acc  = 0;
        m_mode = 0;
        m_last = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clockin);
            tick_in = ~tick_in;
        end
        tick_in = 1'b0;
        repeat (3) @(negedge clockin);
        resetn = 1'b1;
        repeat (4) @(negedge clockin);
        check("post_rst", obs, 0);
        press(1'b0);
        ticks(TPS);
        check("post_rst_count", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0001);

        repeat (5) @(negedge clockin);
        check("sb_drain", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/p2_stopwatch_counter.md
Name: p2_stopwatch_counter

Overview:
Consumes the divided clock produced by the clock divider and maintains an MM:SS stopwatch value as four BCD digits. The divider output is treated as an asynchronous level input. It is synchronised and edge-detected in the system clock domain, then prescaled into one-second increments. Run/pause and clear are single-cycle pulses from the debounced button logic. The digit outputs feed the seven-segment display multiplexer.

Parameters:
TICKS_PER_SEC, 1, number of tick_in rising edges per seconds increment; legal range 1..255; 8-bit prescaler.

Ports:
clockin  input  1  system clock; all state updates on its rising edge
resetn  input  1  asynchronous active-low reset
tick_in  input  1  divided clock from the divider; asynchronous to clockin; level signal
run_tgl  input  1  single-cycle pulse, synchronous to clockin; toggles run/pause
clear  input  1  single-cycle pulse, synchronous to clockin; returns to 00:00 idle
sec_ones  output  4  BCD 0..9
sec_tens  output  4  BCD 0..5
min_ones  output  4  BCD 0..9
min_tens  output  4  BCD 0..5
running  output  1  high while in RUN
wrap  output  1  one-cycle pulse on the 59:59 -> 00:00 rollover

Behaviour:
- Reset (resetn low, asynchronous):
  - state = IDLE; all digits = 0; running = 0; wrap = 0.
  - Sync flops, edge-detect flop and prescaler all = 0.
  - Release of reset is synchronous to clockin.
- Tick path:
  - Two-flop synchroniser sync1 -> sync2, then prev register.
  - tick_pulse = sync2 & ~prev, asserted for exactly one clockin cycle per tick_in rising edge.
  - If tick_in rises with setup met for edge N, tick_pulse is high during the cycle after edge N+1.
  - The counter acts on edge N+2.
  - tick_in falling edges are ignored.
- Prescaler:
  - Counts tick_pulse only in RUN.
  - On a tick_pulse with prescaler == TICKS_PER_SEC-1: prescaler wraps to 0 and a one-second increment occurs on the same edge.
  - Otherwise the prescaler increments.
  - Held in PAUSE. Cleared to 0 on clear and on reset.
- State machine (IDLE, RUN, PAUSE):
  - IDLE --run_tgl--> RUN
  - RUN --run_tgl--> PAUSE
  - PAUSE --run_tgl--> RUN
  - any state --clear--> IDLE
  - running = (state == RUN), registered.
- Priority per edge: clear beats everything.
  - clear together with run_tgl: go to IDLE, digits 0.
  - clear together with a tick: tick discarded, digits 0, wrap = 0.
- Same-edge interactions use current-state semantics:
  - run_tgl and increment on the same edge in RUN: the increment is applied and the next state is PAUSE.
  - run_tgl and tick_pulse on the same edge in PAUSE: the tick is not counted; the next state is RUN.
- Increment (BCD ripple, all on one edge):
  - sec_ones 9 -> 0 carries into sec_tens.
  - sec_tens 5 -> 0 carries into min_ones.
  - min_ones 9 -> 0 carries into min_tens.
  - min_tens 5 -> 0 produces the rollover.
- Rollover: 59:59 -> 00:00.
  - wrap is registered high for the one cycle following that edge.
  - State stays RUN.
- Digits never hold non-BCD values: tens digits 0..5, ones digits 0..9.
- IDLE and PAUSE freeze the digits. Entering RUN from IDLE starts from 00:00 with the prescaler at 0.
- Reset asserted mid-count: immediate return to reset values, no wrap pulse.

Test Plan:
1. Reset: hold resetn=0 with tick_in toggling -> all digits 0, running=0, wrap=0. Release, run_tgl, then one tick_in rise -> sec_ones=1 exactly 3 clockin edges after the rise is first sampled.
2. Counting, TICKS_PER_SEC=1: RUN, apply 70 ticks -> 01:10 (min_ones=1, sec_tens=1, sec_ones=0); running=1 throughout.
3. Prescale, TICKS_PER_SEC=2: RUN, apply 5 ticks -> 00:02 with prescaler=1. Pause, apply 4 ticks -> still 00:02. Resume, 1 tick -> 00:03.
4. Rollover: RUN, apply 3599 ticks -> 59:59. One more tick -> 00:00, wrap high for exactly 1 cycle, running stays 1.
5. Simultaneous events:
   - clear on the same edge as an increment at 00:41 -> 00:00, IDLE, wrap=0.
   - run_tgl on the same edge as an increment in RUN at 00:07 -> 00:08, PAUSE.
   - run_tgl on the same edge as tick_pulse in PAUSE -> digits unchanged, RUN.
6. Async reset mid-count: at 12:34 drive resetn low between clock edges -> outputs 0 immediately, before the next clockin edge. Ticks during reset are ignored.
